// File: rtl/centered_lift_vector_pkg.sv
// Shared constants and types for the centred-lift path (RNS residues back to signed values).
// Q_MOD_L is the odd modulus. LIFT_HALF_Q is its half-range, so centred values lie in [-HALF, +HALF].
package centered_lift_vector_pkg;

  localparam int N           = 8;              // slots per vector
  localparam int W           = 8;              // residue width
  localparam int WW          = 2 * W;          // signed output element width
  localparam int Q_MOD_L     = 251;
  localparam int LIFT_HALF_Q = (Q_MOD_L - 1) / 2;

  typedef logic [W-1:0]                rns_residue_t;
  typedef rns_residue_t [N-1:0]        vec_t;
  typedef logic [N-1:0][WW-1:0]        wide_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LIFT,
    ST_HOLD
  } state_e;

  localparam rns_residue_t Q_RES    = W'(Q_MOD_L);
  localparam rns_residue_t HALF_RES = W'(LIFT_HALF_Q);

endpackage

// File: rtl/centered_lift_vector_if.sv
// Handshake bundle for the lifter. The input side carries a residue vector and
// the output side carries the lifted signed vector.
interface centered_lift_vector_if;
  import centered_lift_vector_pkg::*;

  logic      in_valid;
  logic      in_ready;
  vec_t      in_vec;
  logic      out_valid;
  logic      out_ready;
  wide_vec_t out_vec;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec
  );

endinterface

// File: rtl/centered_lift_lane.sv
// Combinational lift of one residue to its signed centred representative.
// With CLIFT_RANGE_CHECK_EN defined, it also flags r >= Q and forces the lifted value to 0.
module centered_lift_lane
  import centered_lift_vector_pkg::*;
(
  input  rns_residue_t   r_i,
  output logic [WW-1:0]  lift_o
`ifdef CLIFT_RANGE_CHECK_EN
  ,
  output logic           range_err_o
`endif
);

  logic [WW:0] diff;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    diff   = {{(WW + 1 - W){1'b0}}, r_i} - (WW + 1)'(Q_MOD_L);
    lift_o = {{(WW - W){1'b0}}, r_i};
    if (r_i > HALF_RES) begin
      lift_o = WW'(diff);
    end
`ifdef CLIFT_RANGE_CHECK_EN
    range_err_o = (r_i >= Q_RES);
    if (range_err_o) begin
      lift_o = '0;
    end
`endif
  end

endmodule

// File: rtl/centered_lift_vector.sv
// Lifts a vector of N residues to signed centred values, LANES slots per cycle.
// The optional macro CLIFT_RANGE_CHECK_EN adds a sticky range_err output for residues >= Q.
module centered_lift_vector
  import centered_lift_vector_pkg::*;
#(
  parameter int LANES = 4
)(
  input  logic                   clk,
  input  logic                   rst,
  centered_lift_vector_if.slave  bus
`ifdef CLIFT_RANGE_CHECK_EN
  ,
  output logic                   range_err
`endif
);

  localparam int STEPS = N / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if ((N % LANES) != 0) begin : g_bad_lanes
    $error("centered_lift_vector: N must be a multiple of LANES");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  vec_t             buf_q, buf_d;
  wide_vec_t        out_q, out_d;

  rns_residue_t     lane_in  [LANES];
  logic [WW-1:0]    lane_out [LANES];

`ifdef CLIFT_RANGE_CHECK_EN
  logic             err_q, err_d;
  logic [LANES-1:0] lane_err;
`endif

  // The lanes always read the slot group selected by the current count.
  always_comb begin
    logic [IDX_W-1:0] rd_idx;
    for (int l = 0; l < LANES; l++) begin
      rd_idx     = IDX_W'(cnt_q * LANES + l);
      lane_in[l] = buf_q[rd_idx];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    centered_lift_lane u_lane (
      .r_i         (lane_in[l]),
      .lift_o      (lane_out[l])
`ifdef CLIFT_RANGE_CHECK_EN
      ,
      .range_err_o (lane_err[l])
`endif
    );
  end

  always_comb begin
    logic [IDX_W-1:0] wr_idx;
    wr_idx        = '0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    out_d         = out_q;
`ifdef CLIFT_RANGE_CHECK_EN
    err_d         = err_q;
`endif
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          buf_d   = bus.in_vec;
          cnt_d   = '0;
`ifdef CLIFT_RANGE_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = ST_LIFT;
        end
      end

      ST_LIFT: begin
        for (int l = 0; l < LANES; l++) begin
          wr_idx        = IDX_W'(cnt_q * LANES + l);
          out_d[wr_idx] = lane_out[l];
`ifdef CLIFT_RANGE_CHECK_EN
          if (lane_err[l]) begin
            err_d = 1'b1;
          end
`endif
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      // NOTE: the input buffer and output register are reset too, so an aborted vector leaves no residue behind.
      buf_q   <= '0;
      out_q   <= '0;
`ifdef CLIFT_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
`ifdef CLIFT_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.out_vec = out_q;
`ifdef CLIFT_RANGE_CHECK_EN
  assign range_err   = err_q;
`endif

endmodule
